// File: rtl/nice_broadcast_arbiter.sv
// Round-robin arbiter that accepts one item from NUM_SRC publishers and broadcasts it
// to every subscribed destination, retiring it only once all subscribers have taken it.
module nice_broadcast_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int NUM_DST   = 4,
    parameter  int DATA_W    = 32,
    parameter  int CNT_W     = 16,
    localparam int SRC_IDX_W = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_DST-1:0]        dst_mask,
    output logic [NUM_DST-1:0]        dst_valid,
    output logic [DATA_W-1:0]         dst_data,
    input  logic [NUM_DST-1:0]        dst_ready,
    output logic                      busy,
    output logic [SRC_IDX_W-1:0]      grant_id,
    output logic [CNT_W-1:0]          drop_count
);

    typedef enum logic {
        S_IDLE,
        S_BCAST
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [SRC_IDX_W-1:0]   r_last;
    logic [SRC_IDX_W-1:0]   r_grant;
    logic [DATA_W-1:0]      r_data;
    logic [NUM_DST-1:0]     r_mask;
    logic [NUM_DST-1:0]     r_done;
    logic [CNT_W-1:0]       r_drop;

    logic                   w_found;
    logic [SRC_IDX_W-1:0]   w_sel;
    logic                   w_accept;
    logic [NUM_DST-1:0]     w_hs;
    logic                   w_covered;

    function automatic logic [SRC_IDX_W-1:0] rrIndex(input logic [SRC_IDX_W-1:0] base,
                                                     input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_SRC;
        return SRC_IDX_W'(sum);
    endfunction

    // Walk from the farthest candidate to the nearest so the nearest valid one after r_last wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (src_valid[rrIndex(r_last, k)]) begin
                w_found = 1'b1;
                w_sel   = rrIndex(r_last, k);
            end
        end
    end

    assign w_accept  = rst_n && (r_state == S_IDLE) && w_found;
    assign w_hs      = dst_valid & dst_ready;
    assign w_covered = (((r_done | w_hs) & r_mask) == r_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (dst_mask != '0)) begin
                    w_next_state = S_BCAST;
                end
            end
            S_BCAST: begin
                if (w_covered) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        src_ready = '0;
        dst_valid = '0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    src_ready[w_sel] = 1'b1;
                end
            end
            S_BCAST: begin
                busy      = 1'b1;
                dst_valid = r_mask & ~r_done;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // An accept with an empty mask still latches the payload but only bumps the drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= SRC_IDX_W'(NUM_SRC - 1);
            r_grant <= '0;
            r_data  <= '0;
            r_mask  <= '0;
            r_done  <= '0;
            r_drop  <= '0;
        end else if (w_accept) begin
            r_data  <= src_data[w_sel*DATA_W +: DATA_W];
            r_grant <= w_sel;
            r_last  <= w_sel;
            r_mask  <= dst_mask;
            r_done  <= '0;
            if ((dst_mask == '0) && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end else if (r_state == S_BCAST) begin
            r_done <= r_done | w_hs;
        end
    end

    assign dst_data   = r_data;
    assign grant_id   = r_grant;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_nice_broadcast_arbiter.sv
// Scoreboard bench: the driver queues each offered payload per publisher, and a negedge
// monitor predicts grants and broadcasts from round-robin rules and checks every cycle.
module tb_nice_broadcast_arbiter;

    localparam int NS = 4;
    localparam int ND = 4;
    localparam int DW = 32;
    localparam int CW = 3;
    localparam int IW = $clog2(NS);

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    src_valid;
    logic [NS*DW-1:0] src_data;
    logic [NS-1:0]    src_ready;
    logic [ND-1:0]    dst_mask;
    logic [ND-1:0]    dst_valid;
    logic [DW-1:0]    dst_data;
    logic [ND-1:0]    dst_ready;
    logic             busy;
    logic [IW-1:0]    grant_id;
    logic [CW-1:0]    drop_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] expQ [NS][$];
    logic [NS-1:0] offering;
    logic [15:0]   dataCtr;

    bit            mIdle;
    int            mLast;
    int            mGrant;
    int            mDrop;
    int            pick;
    logic [DW-1:0] mData;
    logic [ND-1:0] mRem;
    logic [NS-1:0] expRdy;

    nice_broadcast_arbiter #(
        .NUM_SRC(NS),
        .NUM_DST(ND),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .dst_mask  (dst_mask),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_ready (dst_ready),
        .busy      (busy),
        .grant_id  (grant_id),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding broadcast at a time, grants taken round-robin after the last winner.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_src_ready", 64'(src_ready), 64'(0));
            checkOutput("rst_dst_valid", 64'(dst_valid), 64'(0));
            checkOutput("rst_busy", 64'(busy), 64'(0));
            checkOutput("rst_grant_id", 64'(grant_id), 64'(0));
            checkOutput("rst_dst_data", 64'(dst_data), 64'(0));
            checkOutput("rst_drop_count", 64'(drop_count), 64'(0));
            mIdle  = 1'b1;
            mLast  = NS - 1;
            mGrant = 0;
            mData  = '0;
            mDrop  = 0;
            mRem   = '0;
        end else if (mIdle) begin
            pick = -1;
            for (int k = 1; k <= NS; k++) begin
                if (pick < 0 && src_valid[(mLast + k) % NS]) pick = (mLast + k) % NS;
            end
            expRdy = '0;
            if (pick >= 0) expRdy[pick] = 1'b1;
            checkOutput("idle_src_ready", 64'(src_ready), 64'(expRdy));
            checkOutput("idle_busy", 64'(busy), 64'(0));
            checkOutput("idle_dst_valid", 64'(dst_valid), 64'(0));
            checkOutput("idle_grant_id", 64'(grant_id), 64'(mGrant));
            checkOutput("idle_dst_data", 64'(dst_data), 64'(mData));
            checkOutput("drop_count", 64'(drop_count), 64'(mDrop));
            if (pick >= 0) begin
                if (expQ[pick].size() > 0) mData = expQ[pick].pop_front();
                mGrant = pick;
                mLast  = pick;
                if (dst_mask == '0) begin
                    if (mDrop < (1 << CW) - 1) mDrop++;
                end else begin
                    mIdle = 1'b0;
                    mRem  = dst_mask;
                end
            end
        end else begin
            checkOutput("bcast_src_ready", 64'(src_ready), 64'(0));
            checkOutput("bcast_busy", 64'(busy), 64'(1));
            checkOutput("bcast_dst_valid", 64'(dst_valid), 64'(mRem));
            checkOutput("bcast_dst_data", 64'(dst_data), 64'(mData));
            checkOutput("bcast_grant_id", 64'(grant_id), 64'(mGrant));
            checkOutput("bcast_drop_count", 64'(drop_count), 64'(mDrop));
            mRem = mRem & ~dst_ready;
            if (mRem == '0) mIdle = 1'b1;
        end
    end

    task automatic tick();
        logic [NS-1:0] rdy;
        @(negedge clk);
        rdy = src_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (rdy[i]) begin
                offering[i]  = 1'b0;
                src_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic offer(input int i, input logic [DW-1:0] d);
        if (!offering[i]) begin
            offering[i]          = 1'b1;
            src_valid[i]         = 1'b1;
            src_data[i*DW +: DW] = d;
            expQ[i].push_back(d);
        end
    endtask

    task automatic applyStimulus(input logic [NS-1:0] newOffers, input logic [ND-1:0] mask,
                                 input logic [ND-1:0] ready, input bit randData);
        for (int i = 0; i < NS; i++) begin
            if (newOffers[i] && !offering[i]) begin
                if (randData) begin
                    offer(i, DW'($urandom));
                end else begin
                    offer(i, {16'hA5A5, dataCtr});
                    dataCtr++;
                end
            end
        end
        dst_mask  = mask;
        dst_ready = ready;
        tick();
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_now_dst_valid", 64'(dst_valid), 64'(0));
        checkOutput("rst_now_busy", 64'(busy), 64'(0));
        offering  = '0;
        src_valid = '0;
        for (int i = 0; i < NS; i++) expQ[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        src_valid = '0;
        src_data  = '0;
        dst_mask  = '0;
        dst_ready = '0;
        offering  = '0;
        dataCtr   = 16'h0001;
        #1;
        resetDut();

        // Single item, everyone ready.
        applyStimulus(4'b0001, 4'hF, 4'hF, 1'b0);
        applyStimulus(4'b0000, 4'hF, 4'hF, 1'b0);
        applyStimulus(4'b0000, 4'hF, 4'hF, 1'b0);

        // All publishers valid: grants rotate 0,1,2,3,...
        for (int n = 0; n < 16; n++) applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        for (int n = 0; n < 8; n++) applyStimulus(4'h0, 4'hF, 4'hF, 1'b0);

        // Partial mask with one slow subscriber.
        applyStimulus(4'b0001, 4'b1010, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b0010, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b1000, 1'b0);
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 1'b0);

        // Empty-mask drops until the counter saturates.
        for (int n = 0; n < 10; n++) begin
            applyStimulus(4'b0100, 4'h0, 4'hF, 1'b0);
            applyStimulus(4'b0000, 4'h0, 4'hF, 1'b0);
        end
        checkOutput("drop_saturated", 64'(drop_count), 64'((1 << CW) - 1));

        // Mask changes during a broadcast are ignored.
        applyStimulus(4'b0001, 4'h3, 4'h0, 1'b0);
        applyStimulus(4'b0000, 4'hC, 4'hC, 1'b0);
        applyStimulus(4'b0000, 4'hC, 4'h1, 1'b0);
        applyStimulus(4'b0000, 4'hC, 4'h2, 1'b0);
        applyStimulus(4'b0000, 4'hC, 4'h0, 1'b0);

        // Reset in the middle of a broadcast; next grant must go to publisher 0.
        applyStimulus(4'b0100, 4'h3, 4'h0, 1'b0);
        applyStimulus(4'b0000, 4'h3, 4'h0, 1'b0);
        checkOutput("pre_rst_dst_valid", 64'(dst_valid), 64'(4'h3));
        resetDut();
        applyStimulus(4'hF, 4'hF, 4'hF, 1'b0);
        for (int n = 0; n < 6; n++) applyStimulus(4'h0, 4'hF, 4'hF, 1'b0);

        // Randomized traffic with one reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:0] offers;
            logic [ND-1:0] mask;
            offers = NS'($urandom) & NS'($urandom);
            mask   = ($urandom_range(0, 7) == 0) ? '0 : ND'($urandom);
            applyStimulus(offers, mask, ND'($urandom), 1'b1);
            if (n == 1500) resetDut();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nice_broadcast_arbiter.md
Name: nice_broadcast_arbiter

Overview:
- RTL counterpart of the components broadcaster.
- Round-robin arbitrates NUM_SRC publishers onto one shared broadcast channel. Delivers each accepted item to every subscribed destination with an independent valid/ready handshake per destination.
- A transaction retires only when all subscribed destinations have accepted it.
- Sits between the publisher stream sources and the subscriber fan-out in the fabric.

Parameters:
NUM_SRC, 4, number of publishers (>=2)
NUM_DST, 4, number of subscribers (>=1)
DATA_W, 32, payload width
CNT_W, 16, drop counter width
SRC_IDX_W, $clog2(NUM_SRC) (derived, not overridable), grant index width

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  publisher item valid
src_data  in  NUM_SRC*DATA_W  publisher payloads; publisher i at bits [i*DATA_W +: DATA_W]
src_ready  out  NUM_SRC  one-hot accept to the granted publisher
dst_mask  in  NUM_DST  subscription enable, sampled at accept
dst_valid  out  NUM_DST  per-subscriber item valid
dst_data  out  DATA_W  latched payload, common to all subscribers
dst_ready  in  NUM_DST  per-subscriber accept
busy  out  1  broadcast in progress
grant_id  out  SRC_IDX_W  index of the publisher whose item is held
drop_count  out  CNT_W  items accepted with an empty mask

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - state=IDLE; src_ready=0, dst_valid=0, busy=0.
  - dst_data=0, grant_id=0, drop_count=0.
  - done bits=0, held mask=0.
  - RR pointer last=NUM_SRC-1, so publisher 0 has first priority.
- States: IDLE and BCAST.
- IDLE:
  - If any src_valid, select the first asserted publisher searching from last+1 upward, wrapping modulo NUM_SRC.
  - src_ready[sel]=1 combinationally in the same cycle; combinational src_valid->src_ready path is permitted.
  - On that edge, latch src_data[sel] into dst_data, latch sel into grant_id and last, and latch dst_mask into the held mask. Clear done bits.
  - Held mask nonzero -> BCAST.
  - Held mask zero -> item discarded: drop_count increments (saturating at all-ones), state stays IDLE, busy stays 0. The next arbitration is allowed on the following cycle.
  - No src_valid -> stay IDLE; last unchanged.
- BCAST:
  - busy=1; src_ready=0 for all publishers.
  - dst_valid[i] = held_mask[i] & ~done[i]; dst_data stable for the whole state.
  - done[i] sets on dst_valid[i]&dst_ready[i]. Once done[i] is set, dst_valid[i] drops the next cycle.
  - When (done | this cycle's handshakes) covers held_mask -> IDLE on that edge.
  - No new accept in the completion cycle, so minimum spacing is 2 cycles per item.
- Latency: publisher accepted at cycle t -> dst_valid asserted at t+1. If every subscriber is ready, the item retires at t+1 and the next accept can occur at t+2.
- dst_mask changes during BCAST are ignored; the held mask governs.
- dst_ready with dst_valid=0 is ignored and sets no done bit.
- Fairness: the granted publisher becomes lowest priority. Any continuously valid publisher is granted within NUM_SRC accepts.
- A publisher must hold src_valid/src_data stable until its src_ready; the block does not check this.
- Reset mid-BCAST: the held item is lost and all outputs return to reset values immediately.
- grant_id and dst_data retain their last values in IDLE; consumers qualify them with dst_valid/busy.

Test Plan:
- Reset, then src_valid=4'b0001, data 0xA5A5_0001, dst_mask=4'hF, all dst_ready=1 -> src_ready[0] in cycle 0. dst_valid=4'hF with dst_data=0xA5A5_0001 in cycle 1. busy=0 in cycle 2.
- Hold src_valid=4'hF for 8 items, ready always 1 -> grant_id sequence 0,1,2,3,0,1,2,3, one accept every 2 cycles.
- mask=4'b1010; dst_ready[1] high in cycle 1, dst_ready[3] held low until cycle 5 -> dst_valid[1] drops in cycle 2. dst_valid[3] high cycles 1-5. busy falls after cycle 5; dst_valid[0] and dst_valid[2] never assert.
- dst_mask=0 with src_valid[2]=1 -> src_ready[2] pulses, drop_count 0->1, no dst_valid, busy stays 0. Force drop_count to 16'hFFFF, repeat -> stays 16'hFFFF.
- During BCAST change dst_mask from 4'h3 to 4'hC -> only dst_valid[1:0] assert and the item retires on their handshakes.
- Assert rst_n=0 mid-BCAST with dst_valid=4'h3 pending -> dst_valid=0, busy=0 immediately. After release the next grant goes to publisher 0.
